// File: rtl/ppu_fetch_arbiter.sv
// PPU fetch arbiter: shares one VRAM/OAM read port between the background
// and sprite fetchers. Sprite requests win; one transaction is outstanding
// at a time and a granted transaction is aborted after TIMEOUT T-cycles.
module ppu_fetch_arbiter #(
   parameter int unsigned TIMEOUT = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        tclk_in,
   input  logic [15:0] bg_addr_in,
   input  logic        bg_req_in,
   output logic        bg_data_valid_out,
   input  logic [15:0] spr_addr_in,
   input  logic        spr_req_in,
   output logic        spr_data_valid_out,
   input  logic        spr_hit_in,
   output logic        bg_pause_out,
   output logic [15:0] addr_out,
   output logic        addr_valid_out,
   input  logic        data_valid_in,
   output logic [1:0]  owner_out,
   output logic        timeout_out
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StBgWait  = 2'd1,
      StSprWait = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [15:0]       addr_q, addr_d;
   logic              addr_valid_q, addr_valid_d;
   logic              timeout_q, timeout_d;
   logic              in_wait;

   assign in_wait = (state_q == StBgWait) || (state_q == StSprWait);

   // State and registered outputs; reset overrides every other event.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         addr_q       <= 16'h0000;
         addr_valid_q <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         addr_valid_q <= addr_valid_d;
         timeout_q    <= timeout_d;
      end
   end

   // Grant selection, data return and timeout handling.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      addr_valid_d = 1'b0;
      timeout_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (tclk_in && spr_req_in) begin
               state_d      = StSprWait;
               addr_d       = spr_addr_in;
               addr_valid_d = 1'b1;
               cnt_d        = '0;
            end else if (tclk_in && bg_req_in && !spr_hit_in) begin
               state_d      = StBgWait;
               addr_d       = bg_addr_in;
               addr_valid_d = 1'b1;
               cnt_d        = '0;
            end
         end
         StBgWait, StSprWait: begin
            // Data wins over a coincident timeout.
            if (data_valid_in) begin
               state_d = StIdle;
            end else if (tclk_in) begin
               if (cnt_q == CntW'(TIMEOUT - 1)) begin
                  state_d   = StIdle;
                  timeout_d = 1'b1;
                  cnt_d     = CntW'(TIMEOUT);
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Combinational outputs; gated by reset so the reset cycle shows no owner.
   always_comb begin
      bg_data_valid_out  = 1'b0;
      spr_data_valid_out = 1'b0;
      owner_out          = 2'b00;
      if (!rst_in) begin
         bg_data_valid_out  = (state_q == StBgWait) && data_valid_in;
         spr_data_valid_out = (state_q == StSprWait) && data_valid_in;
         if (state_q == StBgWait) begin
            owner_out = 2'b01;
         end else if (state_q == StSprWait) begin
            owner_out = 2'b10;
         end
      end
      bg_pause_out = spr_hit_in || (state_q == StSprWait);
   end

   assign addr_out       = addr_q;
   assign addr_valid_out = addr_valid_q;
   assign timeout_out    = timeout_q;

   logic unused_in_wait;
   assign unused_in_wait = in_wait;

endmodule

// File: tb/tb_ppu_fetch_arbiter.sv
// Directed self-checking bench for ppu_fetch_arbiter.
module tb_ppu_fetch_arbiter;

   logic        clk = 1'b0;
   logic        rst, tclk, bg_req, spr_req, spr_hit, dv;
   logic [15:0] bg_addr, spr_addr;
   logic        bg_dv, spr_dv, bg_pause, addr_valid, timeout;
   logic [15:0] addr;
   logic [1:0]  owner;
   int          checks = 0;
   int          errors = 0;

   ppu_fetch_arbiter #(.TIMEOUT(8)) dut (
      .clk_in             (clk),
      .rst_in             (rst),
      .tclk_in            (tclk),
      .bg_addr_in         (bg_addr),
      .bg_req_in          (bg_req),
      .bg_data_valid_out  (bg_dv),
      .spr_addr_in        (spr_addr),
      .spr_req_in         (spr_req),
      .spr_data_valid_out (spr_dv),
      .spr_hit_in         (spr_hit),
      .bg_pause_out       (bg_pause),
      .addr_out           (addr),
      .addr_valid_out     (addr_valid),
      .data_valid_in      (dv),
      .owner_out          (owner),
      .timeout_out        (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are sampled 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; tclk = 1'b0; bg_req = 1'b0; spr_req = 1'b0; spr_hit = 1'b0; dv = 1'b0;
      bg_addr = 16'h0; spr_addr = 16'h0;
      step(); step();
      rst = 1'b0;
      #1;
      chk("rst_addr", 32'(addr), 32'h0);
      chk("rst_addr_valid", 32'(addr_valid), 32'h0);
      chk("rst_timeout", 32'(timeout), 32'h0);
      chk("rst_owner", 32'(owner), 32'h0);
      chk("rst_pause", 32'(bg_pause), 32'h0);

      // Data strobe in idle is ignored.
      dv = 1'b1; #1;
      chk("idle_bg_dv", 32'(bg_dv), 32'h0);
      chk("idle_spr_dv", 32'(spr_dv), 32'h0);
      dv = 1'b0;

      // Background grant, data three cycles later.
      bg_req = 1'b1; bg_addr = 16'h9800; tclk = 1'b1;
      step();
      chk("bg_addr", 32'(addr), 32'h9800);
      chk("bg_addr_valid", 32'(addr_valid), 32'h1);
      chk("bg_owner", 32'(owner), 32'h1);
      bg_req = 1'b0; tclk = 1'b0;
      step();
      chk("bg_addr_valid_1cyc", 32'(addr_valid), 32'h0);
      chk("bg_owner_hold", 32'(owner), 32'h1);
      step(); step();
      dv = 1'b1; #1;
      chk("bg_dv", 32'(bg_dv), 32'h1);
      chk("bg_dv_other", 32'(spr_dv), 32'h0);
      step();
      dv = 1'b0; #1;
      chk("bg_done_owner", 32'(owner), 32'h0);
      chk("bg_addr_hold", 32'(addr), 32'h9800);

      // Simultaneous requests: sprite wins.
      bg_req = 1'b1; spr_req = 1'b1; spr_addr = 16'hFE04; bg_addr = 16'h9900; tclk = 1'b1;
      step();
      chk("both_owner", 32'(owner), 32'h2);
      chk("both_addr", 32'(addr), 32'hFE04);
      chk("both_addr_valid", 32'(addr_valid), 32'h1);
      chk("both_pause", 32'(bg_pause), 32'h1);
      bg_req = 1'b0; spr_req = 1'b0; tclk = 1'b0;
      step();
      chk("spr_pause_hold", 32'(bg_pause), 32'h1);
      dv = 1'b1; #1;
      chk("spr_dv", 32'(spr_dv), 32'h1);
      chk("spr_dv_other", 32'(bg_dv), 32'h0);
      step();
      dv = 1'b0; #1;
      chk("spr_done_owner", 32'(owner), 32'h0);
      chk("spr_done_pause", 32'(bg_pause), 32'h0);

      // Sprite hit during BG_WAIT does not pre-empt.
      bg_req = 1'b1; bg_addr = 16'h8000; tclk = 1'b1;
      step();
      chk("hit_bg_owner", 32'(owner), 32'h1);
      bg_req = 1'b0; tclk = 1'b0; spr_hit = 1'b1; spr_req = 1'b1; spr_addr = 16'hFE08; #1;
      chk("hit_pause", 32'(bg_pause), 32'h1);
      step();
      chk("hit_no_preempt", 32'(owner), 32'h1);
      dv = 1'b1; #1;
      chk("hit_bg_dv", 32'(bg_dv), 32'h1);
      step();
      dv = 1'b0; tclk = 1'b1; bg_req = 1'b1;
      step();
      chk("hit_next_owner", 32'(owner), 32'h2);
      chk("hit_next_addr", 32'(addr), 32'hFE08);
      bg_req = 1'b0; spr_req = 1'b0; tclk = 1'b0; spr_hit = 1'b0; dv = 1'b1;
      step();
      dv = 1'b0;

      // Timeout after 8 T-cycles with no data.
      bg_req = 1'b1; bg_addr = 16'h1234; tclk = 1'b1;
      step();
      bg_req = 1'b0;
      for (int i = 0; i < 7; i++) step();
      chk("to_pre_owner", 32'(owner), 32'h1);
      chk("to_pre_pulse", 32'(timeout), 32'h0);
      step();
      chk("to_pulse", 32'(timeout), 32'h1);
      chk("to_owner", 32'(owner), 32'h0);
      chk("to_bg_dv", 32'(bg_dv), 32'h0);
      step();
      chk("to_pulse_1cyc", 32'(timeout), 32'h0);

      // Data coincident with the timeout edge wins.
      bg_req = 1'b1; bg_addr = 16'h2345;
      step();
      bg_req = 1'b0;
      for (int i = 0; i < 7; i++) step();
      dv = 1'b1; #1;
      chk("race_bg_dv", 32'(bg_dv), 32'h1);
      step();
      dv = 1'b0; tclk = 1'b0; #1;
      chk("race_no_timeout", 32'(timeout), 32'h0);
      chk("race_owner", 32'(owner), 32'h0);

      // Reset mid-SPR_WAIT, then a late data strobe.
      spr_req = 1'b1; spr_addr = 16'hFE10; tclk = 1'b1;
      step();
      chk("rw_owner", 32'(owner), 32'h2);
      spr_req = 1'b0; tclk = 1'b0; rst = 1'b1; dv = 1'b1; #1;
      chk("rw_rst_owner", 32'(owner), 32'h0);
      chk("rw_rst_spr_dv", 32'(spr_dv), 32'h0);
      step();
      rst = 1'b0; #1;
      chk("rw_spr_dv", 32'(spr_dv), 32'h0);
      chk("rw_owner_after", 32'(owner), 32'h0);
      chk("rw_addr_valid", 32'(addr_valid), 32'h0);
      chk("rw_addr", 32'(addr), 32'h0);
      step();
      dv = 1'b0;

      // No issue while tclk is low.
      bg_req = 1'b1; bg_addr = 16'h9C00; tclk = 1'b0;
      step(); step();
      chk("tclk0_addr_valid", 32'(addr_valid), 32'h0);
      chk("tclk0_owner", 32'(owner), 32'h0);
      tclk = 1'b1;
      step();
      chk("tclk1_addr_valid", 32'(addr_valid), 32'h1);
      chk("tclk1_addr", 32'(addr), 32'h9C00);
      chk("tclk1_owner", 32'(owner), 32'h1);
      bg_req = 1'b0; tclk = 1'b0; dv = 1'b1;
      step();
      dv = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard bound so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ppu_fetch_arbiter.md
PPU_FETCH_ARBITER -- requirements
Module: ppu_fetch_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8: T-cycles a granted transaction may wait for data before abort.
REQ-002 SHALL have port clk_in, input, 1: global clock; one clock domain, all state updates on its rising edge.
REQ-003 SHALL have port rst_in, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port tclk_in, input, 1: T-cycle enable strobe.
REQ-005 SHALL have port bg_addr_in, input, 16: background fetcher request address.
REQ-006 SHALL have port bg_req_in, input, 1: background fetcher request valid.
REQ-007 SHALL have port bg_data_valid_out, output, 1: data_in is valid for the background fetcher.
REQ-008 SHALL have port spr_addr_in, input, 16: sprite fetcher request address.
REQ-009 SHALL have port spr_req_in, input, 1: sprite fetcher request valid.
REQ-010 SHALL have port spr_data_valid_out, output, 1: data_in is valid for the sprite fetcher.
REQ-011 SHALL have port spr_hit_in, input, 1: sprite detected at current X; background must yield.
REQ-012 SHALL have port bg_pause_out, output, 1: background fetcher must stall.
REQ-013 SHALL have port addr_out, output, 16: address to the shared VRAM/OAM port.
REQ-014 SHALL have port addr_valid_out, output, 1: single-cycle issue strobe for addr_out.
REQ-015 SHALL have port data_valid_in, input, 1: shared memory read data valid.
REQ-016 SHALL have port owner_out, output, 2: current owner; 00 none, 01 bg, 10 sprite.
REQ-017 SHALL have port timeout_out, output, 1: one-cycle pulse when a transaction is aborted.

Function
REQ-018 SHALL implement states IDLE, BG_WAIT, SPR_WAIT; at most one transaction is outstanding.
REQ-019 IDLE: in a cycle with tclk_in=1 and spr_req_in=1, SHALL latch spr_addr_in into addr_out, pulse addr_valid_out, and enter SPR_WAIT.
REQ-020 IDLE: in a cycle with tclk_in=1, spr_req_in=0, bg_req_in=1 and spr_hit_in=0, SHALL latch bg_addr_in, pulse addr_valid_out, and enter BG_WAIT.
REQ-021 When both requests are present in the same cycle, sprite SHALL win; background SHALL never be granted while spr_hit_in=1.
REQ-022 When tclk_in=0, IDLE SHALL issue nothing.
REQ-023 addr_valid_out SHALL be high for exactly one clk_in cycle per grant, registered, in the cycle after the granting edge.
REQ-024 addr_out SHALL hold the last issued address until the next grant.
REQ-025 In BG_WAIT or SPR_WAIT, data_valid_in SHALL drive the owner's data_valid_out combinationally in the same cycle; the other data_valid_out SHALL stay 0.
REQ-026 On that same edge, the state SHALL return to IDLE regardless of tclk_in.
REQ-027 A new grant SHALL be possible no earlier than the next tclk_in cycle after return to IDLE.
REQ-028 data_valid_in SHALL be ignored in IDLE; both data_valid_out SHALL be 0.
REQ-029 A granted transaction SHALL never be pre-empted; spr_hit_in during BG_WAIT only affects bg_pause_out.
REQ-030 A requester dropping its request during WAIT SHALL not cancel the transaction; the data strobe is still routed.
REQ-031 Timeout counter, width $clog2(TIMEOUT+1): cleared on grant, incremented on each tclk_in in WAIT.
REQ-032 When the counter reaches TIMEOUT with no data_valid_in, SHALL pulse timeout_out for one cycle, return to IDLE, and assert no data_valid_out.
REQ-033 data_valid_in coincident with the timeout edge SHALL take precedence: data is routed and no timeout occurs.
REQ-034 bg_pause_out SHALL equal spr_hit_in OR (state==SPR_WAIT), combinationally.
REQ-035 owner_out SHALL be 01 in BG_WAIT, 10 in SPR_WAIT, and 00 in IDLE.

Reset
REQ-036 rst_in=1 at an edge SHALL force IDLE, clear the counter, and set addr_out=0, addr_valid_out=0 and timeout_out=0 from the next cycle.
REQ-037 In the reset cycle and after it, owner_out=00 and both data_valid_out=0; a late data_valid_in after reset mid-WAIT SHALL be ignored.
REQ-038 Reset SHALL take priority over every simultaneous event.

Verification
REQ-039 bg_req=1, bg_addr=0x9800, tclk=1, spr_hit=0 -> addr_out=0x9800, addr_valid 1 cycle, owner=01; data_valid_in 3 cycles later -> bg_data_valid_out=1 same cycle, owner=00.
REQ-040 bg_req and spr_req together, spr_addr=0xFE04 -> sprite granted, addr_out=0xFE04, bg_pause_out=1 until the data strobe.
REQ-041 spr_hit_in=1 asserted while BG_WAIT -> no pre-emption, bg data routed, next grant goes to sprite.
REQ-042 Grant with no data_valid_in for 8 tclk_in -> timeout_out pulses once, owner=00, no data_valid_out.
REQ-043 rst_in mid-SPR_WAIT, then data_valid_in -> spr_data_valid_out=0, addr_valid_out=0, owner=00.
REQ-044 tclk_in=0 with bg_req=1 -> no addr_valid_out until tclk_in=1.
